// File: rtl/wb_select_stage.sv
// ---------------------------------------------------------------------------
// wb_select_stage
//
// Registered writeback-select stage between MEM and WB of the pipelined core.
// One of NSRC packed writeback sources is picked by in_sel and registered
// together with the destination register and the register-file write strobe.
// The stage supports stall (hold) and flush (kill). Writes to x0 are
// suppressed, an out-of-range select raises a sticky error flag, and every
// committed register write is counted.
//
// Handshake/flow: the stage has no ready output. On each rising edge the
// priority is flush > stall > load. A write held in the stage commits on the
// edge where it leaves the stage normally (out_wen=1, stall=0, flush=0).
//
// Optional feature (macro WB_SELECT_FWD_EN):
//   When defined, adds WB->EX forwarding compare ports:
//     fwd_rs1, fwd_rs2 (in)  : EX-stage source register addresses
//     fwd_hit1, fwd_hit2 (out): out_wen & (fwd_rsN == out_rd)
//     fwd_data (out)          : out_data
//   When undefined, those ports and their logic do not exist.
//
// Ports:
//   clk       in   1            core clock, rising edge
//   rst       in   1            asynchronous active-high reset
//   in_valid  in   1            MEM-stage instruction valid
//   in_data   in   NSRC*WIDTH   packed sources, source k = in_data[k*WIDTH +: WIDTH]
//   in_sel    in   SELW         source select
//   in_rd     in   RADDR        destination register
//   in_wen    in   1            instruction writes a register
//   stall     in   1            hold stage contents
//   flush     in   1            kill stage contents
//   out_valid out  1            WB-stage valid
//   out_data  out  WIDTH        selected, registered writeback data
//   out_rd    out  RADDR        registered destination
//   out_wen   out  1            register-file write strobe
//   sel_err   out  1            sticky out-of-range select on a loaded valid instr
//   wb_count  out  CNTW         committed register writes (wraps silently)
// ---------------------------------------------------------------------------
module wb_select_stage #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic [RADDR-1:0]      in_rd,
  input  logic                  in_wen,
  input  logic                  stall,
  input  logic                  flush,
`ifdef WB_SELECT_FWD_EN
  input  logic [RADDR-1:0]      fwd_rs1,
  input  logic [RADDR-1:0]      fwd_rs2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [WIDTH-1:0]      fwd_data,
`endif
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [RADDR-1:0]      out_rd,
  output logic                  out_wen,
  output logic                  sel_err,
  output logic [CNTW-1:0]       wb_count
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             load;
  logic             load_wen;
  logic             commit;

  // Source mux. A select that matches no source leaves sel_bad set and
  // forces zero data, which also covers 2**SELW > NSRC encodings.
  always_comb begin
    sel_data = '0;
    sel_bad  = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign load     = ~flush & ~stall;
  // valid gates the enable; x0 and bad selects never write
  assign load_wen = in_valid & in_wen & (in_rd != '0) & ~sel_bad;
  // the write currently held leaves the stage this edge
  assign commit   = out_wen & load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
    end else if (flush) begin
      // data/rd are don't-care once killed, so they simply hold
      out_valid <= 1'b0;
      out_wen   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_data  <= sel_data;
      out_rd    <= in_rd;
      out_wen   <= load_wen;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (load && in_valid && sel_bad) begin
      sel_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count <= '0;
    end else if (commit) begin
      wb_count <= wb_count + CNTW'(1);
    end
  end

`ifdef WB_SELECT_FWD_EN
  assign fwd_hit1 = out_wen & (fwd_rs1 == out_rd);
  assign fwd_hit2 = out_wen & (fwd_rs2 == out_rd);
  assign fwd_data = out_data;
`endif

endmodule
